// File: rtl/mem_data_ram_ctrl.sv
// mem_data_ram_ctrl: big-endian byte-addressed data RAM with a fixed-latency
// request/response handshake (IDLE/BUSY FSM), lw/lh/lhu/lb/lbu loads and
// sw/sh/sb stores, alignment and mode fault reporting.
// Optional feature macro: MEM_BYTE_ACCESS_EN enables lb, lbu and sb; when it
// is undefined those modes respond with mode_err.
module mem_data_ram_ctrl #(
  parameter int ADDR_BITS = 16,
  parameter int LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  load_mode,
  input  logic [1:0]  store_mode,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic [31:0] read_data,
  output logic        misalign_err,
  output logic        mode_err
);

`ifdef MEM_BYTE_ACCESS_EN
  localparam logic BYTE_EN = 1'b1;
`else
  localparam logic BYTE_EN = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;
  logic accept, finish;

  // Captured request (data path, no reset needed)
  logic                 write_p0;
  logic [2:0]           lmode_p0;
  logic [1:0]           smode_p0;
  logic [ADDR_BITS-1:0] addr_p0;
  logic [31:0]          wdata_p0;

  logic [7:0] mem [0:(2**ADDR_BITS)-1];

  logic [ADDR_BITS-1:0] a0, a1, a2, a3;
  logic [7:0]  b0, b1, b2, b3;
  logic        mis, mode_bad, do_store;
  logic [31:0] load_val;

  // Upper address bits are deliberately ignored so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^address;

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  // State and latency counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: accept in IDLE, count down in BUSY, finish at zero
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
          cnt_next   = 4'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);

  // Capture request fields on acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p0 <= req_write;
      lmode_p0 <= load_mode;
      smode_p0 <= store_mode;
      addr_p0  <= address[ADDR_BITS-1:0];
      wdata_p0 <= write_data;
    end
  end

  assign a0 = addr_p0;
  assign a1 = addr_p0 + ADDR_BITS'(1);
  assign a2 = addr_p0 + ADDR_BITS'(2);
  assign a3 = addr_p0 + ADDR_BITS'(3);
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  // Fault decode: mode validity and alignment of the captured request
  always_comb begin
    mis      = 1'b0;
    mode_bad = 1'b0;
    if (write_p0) begin
      case (smode_p0)
        2'd0:    mis = (addr_p0[1:0] != 2'b00);
        2'd1:    mis = addr_p0[0];
        2'd2:    mode_bad = ~BYTE_EN;
        default: mode_bad = 1'b1;
      endcase
    end else begin
      case (lmode_p0)
        3'd0:       mis = (addr_p0[1:0] != 2'b00);
        3'd1, 3'd2: mis = addr_p0[0];
        3'd3, 3'd4: mode_bad = ~BYTE_EN;
        default:    mode_bad = 1'b1;
      endcase
    end
  end

  // Big-endian load formatting with sign/zero extension
  always_comb begin
    load_val = 32'd0;
    case (lmode_p0)
      3'd0:    load_val = {b0, b1, b2, b3};
      3'd1:    load_val = ext16({b0, b1}, 1'b1);
      3'd2:    load_val = ext16({b0, b1}, 1'b0);
      3'd3:    load_val = ext8(b0, 1'b1);
      3'd4:    load_val = ext8(b0, 1'b0);
      default: load_val = 32'd0;
    endcase
  end

  assign do_store = finish & write_p0 & ~mis & ~mode_bad;

  // Array write on the responding edge, only the addressed bytes
  always_ff @(posedge clk) begin
    if (do_store) begin
      case (smode_p0)
        2'd0: begin
          mem[a0] <= wdata_p0[31:24];
          mem[a1] <= wdata_p0[23:16];
          mem[a2] <= wdata_p0[15:8];
          mem[a3] <= wdata_p0[7:0];
        end
        2'd1: begin
          mem[a0] <= wdata_p0[15:8];
          mem[a1] <= wdata_p0[7:0];
        end
        default: mem[a0] <= wdata_p0[7:0];
      endcase
    end
  end

  // Response outputs: one-cycle pulse, flags only with the pulse, data held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid   <= 1'b0;
      read_data    <= 32'd0;
      misalign_err <= 1'b0;
      mode_err     <= 1'b0;
    end else begin
      resp_valid   <= finish;
      misalign_err <= finish & mis & ~mode_bad;
      mode_err     <= finish & mode_bad;
      if (finish) begin
        if (mis || mode_bad) begin
          read_data <= 32'd0;
        end else if (!write_p0) begin
          read_data <= load_val;
        end
      end
    end
  end

endmodule
